pmic_power_sequencer: RTL

- Generalised N-rail, M-stage power sequencer. Replaces fixed per-rail monitors and fixed three-stage good chains with one parametrised block.
- Enables stages in ascending order. Verifies each stage's rails within a startup window, then monitors all enabled rails with debounced fault detection.
- On a fault, removes all stage enables at once and latches the fault. On a disable request, shuts stages down in reverse order.
- Sits between the rail supervisor inputs and the regulator enable and status pins.

---
 rtl/pmic_power_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pmic_power_sequencer.sv
// Parametrised N-rail / M-stage power sequencer: ordered ramp, debounced runtime monitoring, reverse shutdown.
// Build macro PMIC_SEQ_AUTO_RETRY_EN adds timed automatic restart out of FAULT (RETRY_DELAY, MAX_RETRIES, o_retryCount).
module pmic_power_sequencer #(
    parameter int NUM_RAILS      = 4,
    parameter int NUM_STAGES     = 3,
    parameter logic [NUM_STAGES*NUM_RAILS-1:0] STAGE_MASK = {4'b1000, 4'b0110, 4'b0001},
    parameter int STARTUP_DELAY  = 1000,
    parameter int ERROR_DELAY    = 3000,
    parameter int SHUTDOWN_DELAY = 500,
    parameter int TIMER_W        = 16
`ifdef PMIC_SEQ_AUTO_RETRY_EN
    ,
    parameter int RETRY_DELAY    = 10000,
    parameter int MAX_RETRIES    = 3
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_faultClear,
    input  logic [NUM_RAILS-1:0]  i_voltageGood,
    input  logic [NUM_RAILS-1:0]  i_currentGood,
    output logic [NUM_STAGES-1:0] o_stageEnable,
    output logic [NUM_STAGES-1:0] o_stageGood,
    output logic [NUM_RAILS-1:0]  o_railGood,
    output logic [NUM_RAILS-1:0]  o_voltageFault,
    output logic [NUM_RAILS-1:0]  o_currentFault,
    output logic [3:0]            o_faultRail,
    output logic                  o_timeoutFault,
`ifdef PMIC_SEQ_AUTO_RETRY_EN
    output logic [3:0]            o_retryCount,
`endif
    output logic [2:0]            o_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0]   LAST_STAGE = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX    = IDX_W'(1);
    localparam logic [TIMER_W-1:0] ONE_T      = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] RAMP_LAST  = TIMER_W'(STARTUP_DELAY - 1);
    localparam logic [TIMER_W-1:0] ERR_LAST   = TIMER_W'(ERROR_DELAY - 1);
    localparam logic [TIMER_W-1:0] SHDN_LAST  = TIMER_W'(SHUTDOWN_DELAY - 1);
`ifdef PMIC_SEQ_AUTO_RETRY_EN
    localparam logic [TIMER_W-1:0] RETRY_LAST = TIMER_W'(RETRY_DELAY - 1);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        RUN      = 3'd2,
        SHUTDOWN = 3'd3,
        FAULT    = 3'd4
    } seqStateT;

    seqStateT               state;
    logic [IDX_W-1:0]       stageIdx;
    logic [TIMER_W-1:0]     timer;
    logic [NUM_STAGES-1:0]  stageEnable;
    logic [NUM_STAGES-1:0]  stageGood;
    logic [NUM_RAILS-1:0]   vFault;
    logic [NUM_RAILS-1:0]   cFault;
    logic                   timeoutFault;
`ifdef PMIC_SEQ_AUTO_RETRY_EN
    logic [3:0]             retryCount;
`endif

    logic [NUM_RAILS-1:0]   vSync_p0, vSync_p1;
    logic [NUM_RAILS-1:0]   cSync_p0, cSync_p1;
    logic [TIMER_W-1:0]     vCnt [NUM_RAILS];
    logic [TIMER_W-1:0]     cCnt [NUM_RAILS];

    logic [NUM_RAILS-1:0]   monMask;
    logic [NUM_RAILS-1:0]   curMask;
    logic [NUM_RAILS-1:0]   vTrip, cTrip;
    logic [NUM_RAILS-1:0]   vStartFail, cStartFail;
    logic [IDX_W-1:0]       nextIdx;
    logic                   rampDone;
    logic                   timeoutHit;
    logic                   runFault;
    logic                   faultEntry;

    function automatic logic [3:0] lowestIdx(input logic [NUM_RAILS-1:0] v);
        lowestIdx = '0;
        for (int r = NUM_RAILS - 1; r >= 0; r--) begin
            if (v[r]) lowestIdx = 4'(r);
        end
    endfunction

    // Stage p0 -> p1: two-flop synchronisers for the asynchronous supervisor inputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vSync_p0 <= '0;
            vSync_p1 <= '0;
            cSync_p0 <= '0;
            cSync_p1 <= '0;
        end else begin
            vSync_p0 <= i_voltageGood;
            vSync_p1 <= vSync_p0;
            cSync_p0 <= i_currentGood;
            cSync_p1 <= cSync_p0;
        end
    end

    // Rails under watch are those of verified stages; curMask selects the ramping stage's rails
    always_comb begin
        monMask = '0;
        curMask = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (stageGood[s]) monMask = monMask | STAGE_MASK[s*NUM_RAILS +: NUM_RAILS];
            if (IDX_W'(s) == stageIdx) curMask = STAGE_MASK[s*NUM_RAILS +: NUM_RAILS];
        end
    end

    always_comb begin
        vTrip = '0;
        cTrip = '0;
        for (int r = 0; r < NUM_RAILS; r++) begin
            vTrip[r] = monMask[r] && !vSync_p1[r] && (vCnt[r] == ERR_LAST);
            cTrip[r] = monMask[r] && !cSync_p1[r] && (cCnt[r] == ERR_LAST);
        end
    end

    assign vStartFail = curMask & ~vSync_p1;
    assign cStartFail = curMask & ~cSync_p1;
    assign nextIdx    = stageIdx + ONE_IDX;
    assign rampDone   = (timer == RAMP_LAST);
    assign timeoutHit = (state == RAMP) && rampDone && (|(vStartFail | cStartFail));
    assign runFault   = |(vTrip | cTrip);
    assign faultEntry = runFault || timeoutHit;

    // Debounce counters: run while a monitored signal is low, clear as soon as it recovers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_RAILS; r++) begin
                vCnt[r] <= '0;
                cCnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RAILS; r++) begin
                if (monMask[r] && !vSync_p1[r]) vCnt[r] <= vCnt[r] + ONE_T;
                else                            vCnt[r] <= '0;
                if (monMask[r] && !cSync_p1[r]) cCnt[r] <= cCnt[r] + ONE_T;
                else                            cCnt[r] <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            stageIdx     <= '0;
            timer        <= '0;
            stageEnable  <= '0;
            stageGood    <= '0;
            vFault       <= '0;
            cFault       <= '0;
            timeoutFault <= 1'b0;
`ifdef PMIC_SEQ_AUTO_RETRY_EN
            retryCount   <= '0;
`endif
        end else if (faultEntry) begin
            // Any fault cuts every regulator at once; it outranks a simultaneous disable request
            state        <= FAULT;
            timer        <= '0;
            stageEnable  <= '0;
            stageGood    <= '0;
            vFault       <= vFault | vTrip | (timeoutHit ? vStartFail : '0);
            cFault       <= cFault | cTrip | (timeoutHit ? cStartFail : '0);
            if (timeoutHit) timeoutFault <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    stageEnable <= '0;
                    stageGood   <= '0;
                    timer       <= '0;
                    stageIdx    <= '0;
                    if (i_enable) begin
                        state          <= RAMP;
                        stageEnable[0] <= 1'b1;
                    end
                end

                RAMP, RUN: begin
                    if (!i_enable) begin
                        // stageIdx is the highest enabled stage in both RAMP and RUN
                        stageEnable[stageIdx] <= 1'b0;
                        stageGood[stageIdx]   <= 1'b0;
                        timer                 <= '0;
                        if (stageIdx == '0) begin
                            state <= IDLE;
                        end else begin
                            state    <= SHUTDOWN;
                            stageIdx <= stageIdx - ONE_IDX;
                        end
                    end else if (state == RAMP) begin
                        if (rampDone) begin
                            stageGood[stageIdx] <= 1'b1;
                            timer               <= '0;
                            if (stageIdx == LAST_STAGE) begin
                                state <= RUN;
                            end else begin
                                stageIdx             <= nextIdx;
                                stageEnable[nextIdx] <= 1'b1;
                            end
                        end else begin
                            timer <= timer + ONE_T;
                        end
                    end
`ifdef PMIC_SEQ_AUTO_RETRY_EN
                    else if (timer != RAMP_LAST) begin
                        timer <= timer + ONE_T;
                    end else begin
                        retryCount <= '0;
                    end
`endif
                end

                SHUTDOWN: begin
                    if (timer == SHDN_LAST) begin
                        stageEnable[stageIdx] <= 1'b0;
                        stageGood[stageIdx]   <= 1'b0;
                        timer                 <= '0;
                        if (stageIdx == '0) state <= IDLE;
                        else                stageIdx <= stageIdx - ONE_IDX;
                    end else begin
                        timer <= timer + ONE_T;
                    end
                end

                FAULT: begin
                    if (i_faultClear && !i_enable) begin
                        state        <= IDLE;
                        timer        <= '0;
                        stageIdx     <= '0;
                        vFault       <= '0;
                        cFault       <= '0;
                        timeoutFault <= 1'b0;
                    end
`ifdef PMIC_SEQ_AUTO_RETRY_EN
                    else if (!i_enable) begin
                        timer <= '0;
                    end else if (timer != RETRY_LAST) begin
                        timer <= timer + ONE_T;
                    end else if (retryCount < 4'(MAX_RETRIES)) begin
                        state          <= RAMP;
                        timer          <= '0;
                        stageIdx       <= '0;
                        stageEnable[0] <= 1'b1;
                        vFault         <= '0;
                        cFault         <= '0;
                        timeoutFault   <= 1'b0;
                        retryCount     <= retryCount + 4'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign o_stageEnable  = stageEnable;
    assign o_stageGood    = stageGood;
    assign o_railGood     = monMask & ~(vFault | cFault);
    assign o_voltageFault = vFault;
    assign o_currentFault = cFault;
    assign o_faultRail    = lowestIdx(vFault | cFault);
    assign o_timeoutFault = timeoutFault;
    assign o_state        = state;
`ifdef PMIC_SEQ_AUTO_RETRY_EN
    assign o_retryCount   = retryCount;
`endif

endmodule
